// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage:
// FSM state encoding, reset PC default and instruction field positions.
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register holding {valid, pc, inst}. Flush clears only the
// valid bit; load captures a new entry; neither means hold.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         load_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC/FSM driving the imem handshake, a one-entry
// skid buffer across decode stalls, branch flush, and the IF/ID field split.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  fetch_entry_t buf_q, buf_d;

  logic         ifid_load, ifid_flush;
  fetch_entry_t ifid_entry, id_entry;
  logic [31:0]  target_aligned, pc_plus4;

  assign target_aligned = word_align(branch_target);
  assign pc_plus4       = pc_q + 32'd4;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_d        = buf_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_entry   = '{pc: pc_q, inst: imem_rdata};

    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (branch_taken) begin
          pc_d       = target_aligned;
          ifid_flush = 1'b1;
          // Without a response this cycle the old request is still open and
          // its address must stay on the bus until it completes.
          if (!imem_valid) begin
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end else if (imem_valid) begin
          pc_d = pc_plus4;
          if (stall) begin
            buf_d   = '{pc: pc_q, inst: imem_rdata};
            state_d = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          pc_d       = target_aligned;
          ifid_flush = 1'b1;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          ifid_entry = buf_q;
          ifid_load  = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (branch_taken) pc_d = target_aligned;
        if (imem_valid)   state_d = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the skid buffer is reset even though its validity lives in the FSM
  // state; it is a single entry, and a known value keeps reset behaviour clean.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= PC_RESET;
      drain_addr_q <= '0;
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_q        <= buf_d;
    end
  end

  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

  fetch_stage_if_id_reg u_if_id_reg (
    .clock   (clock),
    .reset   (reset),
    .flush_i (ifid_flush),
    .load_i  (ifid_load),
    .entry_i (ifid_entry),
    .valid_o (id_valid),
    .entry_o (id_entry)
  );

  assign id_pc     = id_entry.pc;
  assign id_inst   = id_entry.inst;
  assign id_pc4    = id_entry.pc + 32'd4;
  assign id_opcode = id_inst[OPCODE_MSB:OPCODE_LSB];
  assign id_rs     = id_inst[RS_MSB:RS_LSB];
  assign id_rt     = id_inst[RT_MSB:RT_LSB];
  assign id_rd     = id_inst[RD_MSB:RD_LSB];
  assign id_funct  = id_inst[FUNCT_MSB:FUNCT_LSB];
  assign id_imm16  = id_inst[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_fetch_stage;

  localparam logic [31:0] PC_RST = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_pc, id_pc4, id_inst;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fetch_stage #(.PC_RESET(PC_RST)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4),
    .id_inst       (id_inst),
    .id_opcode     (id_opcode),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_funct      (id_funct),
    .id_imm16      (id_imm16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Reference model: "started" flag, next fetch address, a pending-delivery
  // queue for instructions fetched during a stall, and a discard flag for a
  // response that a branch has made stale.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  bit          m_active;
  bit          m_discard;
  logic [31:0] m_pc, m_drain;
  ent_t        m_pend[$];
  bit          m_v;
  logic [31:0] m_ipc, m_inst;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 0; m_discard = 0; m_pc = PC_RST; m_drain = 0;
      m_pend.delete(); m_v = 0; m_ipc = 0; m_inst = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (m_pend.size() != 0) begin
      if (branch_taken) begin
        m_pend.delete(); m_v = 0; m_pc = branch_target & 32'hFFFF_FFFC;
      end else if (!stall) begin
        ent_t e;
        e = m_pend.pop_front();
        m_v = 1; m_ipc = e.pc; m_inst = e.inst;
      end
    end else if (m_discard) begin
      if (branch_taken) m_pc = branch_target & 32'hFFFF_FFFC;
      if (imem_valid)   m_discard = 0;
    end else begin
      if (branch_taken) begin
        m_v = 0;
        if (!imem_valid) begin m_discard = 1; m_drain = m_pc; end
        m_pc = branch_target & 32'hFFFF_FFFC;
      end else if (imem_valid) begin
        if (stall) m_pend.push_back('{pc: m_pc, inst: imem_rdata});
        else begin m_v = 1; m_ipc = m_pc; m_inst = imem_rdata; end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        m_v = 0;
      end
    end
  end

  always @(negedge clock) begin
    check("imem_req",  32'(imem_req), 32'(m_active && (m_pend.size() == 0)));
    check("imem_addr", imem_addr, (m_active && m_discard) ? m_drain : m_pc);
    check("id_valid",  32'(id_valid), 32'(m_v));
    if (m_v) begin
      check("id_pc",     id_pc,            m_ipc);
      check("id_pc4",    id_pc4,           m_ipc + 32'd4);
      check("id_inst",   id_inst,          m_inst);
      check("id_opcode", 32'(id_opcode),   m_inst >> 26);
      check("id_rs",     32'(id_rs),       (m_inst >> 21) & 32'h1F);
      check("id_rt",     32'(id_rt),       (m_inst >> 16) & 32'h1F);
      check("id_rd",     32'(id_rd),       (m_inst >> 11) & 32'h1F);
      check("id_funct",  32'(id_funct),    m_inst & 32'h3F);
      check("id_imm16",  32'(id_imm16),    m_inst & 32'hFFFF);
    end
  end

  task automatic step(input logic v, input logic [31:0] rd, input logic st,
                      input logic br, input logic [31:0] tgt);
    imem_valid = v; imem_rdata = rd; stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clock);
    #2;
  endtask

  // Zero-latency memory: answers whenever a request is up.
  task automatic mem(input logic st);
    step(imem_req, mem_word(imem_addr), st, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    imem_valid = 0; imem_rdata = 0; stall = 0; branch_taken = 0; branch_target = 0;
    #1 reset = 1'b1;
    @(posedge clock); @(posedge clock); #2;
    check("rst_req",   32'(imem_req), 32'h0);
    check("rst_valid", 32'(id_valid), 32'h0);
    check("rst_inst",  id_inst, 32'h0);
    check("rst_pc",    id_pc, 32'h0);
    check("rst_addr",  imem_addr, 32'h0040_0000);
    reset = 1'b0;

    // Startup and zero-latency streaming
    step(1'b1, 32'hFFFF_FFFF, 0, 0, 0);
    check("start_req",  32'(imem_req), 32'h1);
    check("start_addr", imem_addr, 32'h0040_0000);
    check("start_idv",  32'(id_valid), 32'h0);
    mem(0);
    check("s1_addr", imem_addr, 32'h0040_0004);
    check("s1_pc",   id_pc, 32'h0040_0000);
    check("s1_pc4",  id_pc4, 32'h0040_0004);
    mem(0);
    check("s2_addr", imem_addr, 32'h0040_0008);
    check("s2_pc",   id_pc, 32'h0040_0004);

    // addi field split
    step(1'b1, 32'h2008_FFFF, 0, 0, 0);
    check("addi_op",  32'(id_opcode), 32'd8);
    check("addi_rs",  32'(id_rs), 32'd0);
    check("addi_rt",  32'(id_rt), 32'd8);
    check("addi_imm", 32'(id_imm16), 32'h0000_FFFF);

    // Branch while the request is still pending for two more cycles
    step(1'b0, 32'h0, 0, 1, 32'h0040_0100);
    check("br_addr0", imem_addr, 32'h0040_000C);
    check("br_idv0",  32'(id_valid), 32'h0);
    step(1'b0, 32'h0, 0, 0, 0);
    check("br_addr1", imem_addr, 32'h0040_000C);
    step(1'b1, 32'hDEAD_BEEF, 0, 0, 0);
    check("br_addr2", imem_addr, 32'h0040_0100);
    check("br_idv2",  32'(id_valid), 32'h0);
    mem(0);
    check("br_pc", id_pc, 32'h0040_0100);

    // Two branches during a drain: latest target wins, misaligned bits cleared
    step(1'b0, 32'h0, 0, 1, 32'h0040_0200);
    step(1'b0, 32'h0, 0, 1, 32'h0040_0303);
    check("drn_addr", imem_addr, 32'h0040_0104);
    step(1'b1, 32'h1111_1111, 0, 0, 0);
    check("latest_addr", imem_addr, 32'h0040_0300);

    // Reset in the middle of a drain; the late response must be ignored
    step(1'b0, 32'h0, 0, 1, 32'h0040_0500);
    check("pre_rst_addr", imem_addr, 32'h0040_0300);
    reset = 1'b1;
    #1;
    check("mid_rst_req",  32'(imem_req), 32'h0);
    check("mid_rst_idv",  32'(id_valid), 32'h0);
    check("mid_rst_inst", id_inst, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0040_0000);
    step(1'b0, 32'h0, 0, 0, 0);
    reset = 1'b0;
    step(1'b1, 32'hBAD0_BAD0, 0, 0, 0);
    check("restart_addr", imem_addr, 32'h0040_0000);
    check("restart_idv",  32'(id_valid), 32'h0);

    // Three-cycle stall as the second instruction returns
    mem(0);
    mem(1);
    check("hold_pc",  id_pc, 32'h0040_0000);
    check("hold_req", 32'(imem_req), 32'h0);
    mem(1);
    mem(1);
    check("hold3_pc", id_pc, 32'h0040_0000);
    mem(0);
    check("rel_pc",   id_pc, 32'h0040_0004);
    check("rel_inst", id_inst, mem_word(32'h0040_0004));
    check("rel_addr", imem_addr, 32'h0040_0008);
    mem(0);
    check("next_pc", id_pc, 32'h0040_0008);

    // Stall and branch together while holding: branch wins
    mem(1);
    step(1'b0, 32'h0, 1, 1, 32'h0040_0400);
    check("sb_idv",  32'(id_valid), 32'h0);
    check("sb_addr", imem_addr, 32'h0040_0400);
    mem(0);
    check("sb_pc", id_pc, 32'h0040_0400);

    // Stall without data keeps IF/ID; no data and no stall makes a bubble
    step(1'b0, 32'h0, 1, 0, 0);
    check("keep_idv", 32'(id_valid), 32'h1);
    step(1'b0, 32'h0, 0, 0, 0);
    check("bubble_idv", 32'(id_valid), 32'h0);

    // Branch with data the same cycle drops it; PC wraps at the top
    step(1'b1, 32'h2222_2222, 0, 1, 32'hFFFF_FFFC);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    mem(0);
    check("wrap_pc",    id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4",   id_pc4, 32'h0000_0000);
    check("wrap_addr1", imem_addr, 32'h0000_0000);
    mem(0);
    check("wrap_pc0", id_pc, 32'h0000_0000);

    step(1'b0, 32'h0, 0, 0, 0);
    step(1'b0, 32'h0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
